pbtn_event_ctrl: RTL
====================

# pbtn_event_ctrl

Converts the debounced pushbutton levels into single-cycle press, release, long-press and auto-repeat event pulses, plus a sticky press-event register with a masked clear. It sits directly downstream of the pushbutton/switch debouncer and feeds the Rojobot CPU I/O interface and the display control logic. All buttons are processed in parallel by identical per-button state machines driven from one shared millisecond tick.

## Interface
- CLK_FREQUENCY_HZ, 50_000_000, system clock frequency; sets the 1 ms tick prescaler.
- NUM_BTNS, 6, number of buttons handled; range 1..16.
- LONG_PRESS_MS, 500, hold time in ticks before `long_pulse`; range 1..65535.
- REPEAT_MS, 100, auto-repeat period in ticks after a long press; range 1..65535.
- SIMULATE, 0, when 1 the tick fires every clock and the simulate counts below replace the ms counts.
- SIMULATE_LONG_CNT, 20, long-press tick count used when SIMULATE=1.
- SIMULATE_REPEAT_CNT, 5, repeat tick count used when SIMULATE=1.
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pbtn_db  in  NUM_BTNS  debounced button levels, 1 = pressed; already synchronous to clk.
- clr_strobe  in  1  one-cycle request to clear sticky bits.
- clr_mask  in  NUM_BTNS  sticky bits to clear when clr_strobe=1.
- press_pulse  out  NUM_BTNS  one-cycle pulse on press.
- release_pulse  out  NUM_BTNS  one-cycle pulse on release.
- long_pulse  out  NUM_BTNS  one-cycle pulse when the hold reaches the long threshold.
- repeat_pulse  out  NUM_BTNS  one-cycle pulse each repeat period after a long press.
- held  out  NUM_BTNS  level; 1 while the button's FSM is not IDLE.
- press_sticky  out  NUM_BTNS  latched press or repeat events, cleared by mask.

## Operation
- Tick prescaler: counts 0..(CLK_FREQUENCY_HZ/1000 − 1) and asserts `tick` for 1 cycle on wrap. SIMULATE=1 holds `tick` at 1 permanently.
- Thresholds: LONG_CNT = SIMULATE ? SIMULATE_LONG_CNT : LONG_PRESS_MS. REPEAT_CNT = SIMULATE ? SIMULATE_REPEAT_CNT : REPEAT_MS.
- Per-button FSM has states IDLE, HELD and REPEAT, with a 16-bit tick counter `hcnt`.
  - In IDLE, pbtn_db=1 causes `press_pulse`, sets hcnt=0 and moves to HELD.
  - In HELD, each tick increments hcnt. The tick on which hcnt+1 == LONG_CNT causes `long_pulse`, sets hcnt=0 and moves to REPEAT.
  - In REPEAT, each tick increments hcnt. The tick on which hcnt+1 == REPEAT_CNT causes `repeat_pulse` and sets hcnt=0.
  - In HELD or REPEAT, pbtn_db=0 causes `release_pulse` and moves to IDLE. Release takes priority over a coincident tick, so no long or repeat pulse is emitted in that cycle.
- `hcnt` never wraps, because it is reset at each threshold.
- Sticky register: a bit is set by `press_pulse` or `repeat_pulse` and cleared by `clr_strobe & clr_mask`. If set and clear hit the same bit in the same cycle, set wins.
- Buttons are fully independent; simultaneous events on several buttons are all reported in the same cycle.

## Timing
- All outputs are registered. Reset value of every output is 0, all FSMs are in IDLE, and the prescaler is at 0.
- Latency: if pbtn_db changes before clock edge k, the corresponding press or release pulse is high in the cycle following edge k (1 cycle).
- Long and repeat pulses are high in the cycle following the qualifying tick edge.
- `held` rises together with `press_pulse` and falls together with `release_pulse`.
- A sticky bit is visible in the cycle after the pulse edge, and reads 0 in the cycle after a clear edge.
- Asserting reset_n low mid-hold forces all outputs to 0 immediately, with no release pulse. After deassertion, a button still held produces a fresh `press_pulse` 1 cycle later.
- A press of at least 1 cycle always yields a press/release pulse pair.

## Structure
- Package `pbtn_event_pkg` contains:
  - the state enum (IDLE, HELD, REPEAT);
  - the counter width constant HCNT_W=16;
  - the function computing the prescaler top count.
- Sub-module `pbtn_event_fsm` implements one button's FSM, counter and sticky bit. The top level instantiates the prescaler and NUM_BTNS copies of `pbtn_event_fsm` via generate.

## Test plan
All scenarios use SIMULATE=1 with LONG=20 and REPEAT=5.
- Reset: hold reset_n=0 with pbtn_db=6'h3F → all outputs 0. Release reset → `press_pulse`=6'h3F in the next cycle and `held`=6'h3F.
- Short press: pbtn_db[2]=1 for 5 cycles → `press_pulse`[2] in cycle 1, `release_pulse`[2] 1 cycle after the drop, and no long pulse.
- Long hold: pbtn_db[1] held for 40 cycles → `long_pulse` at tick 20, then `repeat_pulse` at ticks 25, 30, 35 and 40, then `release_pulse` after the drop.
- Sticky: pbtn_db[3] pressed → `press_sticky`[3]=1. `clr_strobe` with mask 6'h08 → bit cleared next cycle. Clear coincident with a repeat pulse → bit stays 1.
- Reset mid-hold: reset_n pulsed low at tick 10 of a hold → outputs 0 with no release. After reset, still held → new press, and `long_pulse` 20 ticks later.
- Simultaneous buttons: bits 0 and 5 pressed in the same cycle → `press_pulse`=6'h21. Release bit 5 only → `release_pulse`=6'h20 while bit 0 continues to long press.

Source files
------------

// File: rtl/pbtn_event_pkg.sv
// Shared types and constants for the pushbutton event controller:
// per-button state encoding, hold-counter width and prescaler sizing.
package pbtn_event_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_e;

  localparam int HCNT_W = 16;

  // Terminal count of the 1 ms prescaler; clamped so tiny clocks still tick.
  function automatic int prescale_top(input int clk_hz);
    int top;
    top = (clk_hz / 1000) - 1;
    return (top < 0) ? 0 : top;
  endfunction

endpackage

// File: rtl/pbtn_event_fsm.sv
// One button's event state machine: press/release/long/repeat pulses,
// hold-time counter and the sticky press-event bit.
module pbtn_event_fsm
  import pbtn_event_pkg::*;
#(
  parameter int LONG_CNT   = 500,
  parameter int REPEAT_CNT = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic pbtn,
  input  logic clr,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held,
  output logic press_sticky
);

  localparam logic [HCNT_W-1:0] LONG_TOP   = LONG_CNT[HCNT_W-1:0];
  localparam logic [HCNT_W-1:0] REPEAT_TOP = REPEAT_CNT[HCNT_W-1:0];

  btn_state_e        state_reg, state_next;
  logic [HCNT_W-1:0] hcnt_reg, hcnt_next;
  logic [HCNT_W-1:0] hcnt_inc;
  logic              press_next, release_next, long_next, repeat_next, held_next;
  logic              sticky_next;

  assign hcnt_inc = hcnt_reg + {{(HCNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      hcnt_reg      <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
      press_sticky  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hcnt_reg      <= hcnt_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      long_pulse    <= long_next;
      repeat_pulse  <= repeat_next;
      held          <= held_next;
      press_sticky  <= sticky_next;
    end
  end

  // Release is checked before the tick so it always wins a coincident threshold.
  always_comb begin
    state_next = state_reg;
    hcnt_next  = hcnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (pbtn) begin
          state_next = HELD;
          hcnt_next  = '0;
        end
      end
      HELD: begin
        if (!pbtn) begin
          state_next = IDLE;
        end else if (tick) begin
          if (hcnt_inc == LONG_TOP) begin
            state_next = REPEAT;
            hcnt_next  = '0;
          end else begin
            hcnt_next = hcnt_inc;
          end
        end
      end
      REPEAT: begin
        if (!pbtn) begin
          state_next = IDLE;
        end else if (tick) begin
          hcnt_next = (hcnt_inc == REPEAT_TOP) ? '0 : hcnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        hcnt_next  = '0;
      end
    endcase
  end

  always_comb begin
    press_next   = (state_reg == IDLE) && pbtn;
    release_next = (state_reg != IDLE) && !pbtn;
    long_next    = (state_reg == HELD) && pbtn && tick && (hcnt_inc == LONG_TOP);
    repeat_next  = (state_reg == REPEAT) && pbtn && tick && (hcnt_inc == REPEAT_TOP);
    held_next    = (state_next != IDLE);
    // Sticky sets from the visible pulses; a set beats a same-cycle clear.
    sticky_next  = (press_sticky & ~clr) | press_pulse | repeat_pulse;
  end

endmodule

// File: rtl/pbtn_event_ctrl.sv
// Pushbutton event controller: shared 1 ms tick prescaler feeding one
// identical event FSM per debounced button.
module pbtn_event_ctrl
  import pbtn_event_pkg::*;
#(
  parameter int CLK_FREQUENCY_HZ    = 50_000_000,
  parameter int NUM_BTNS            = 6,
  parameter int LONG_PRESS_MS       = 500,
  parameter int REPEAT_MS           = 100,
  parameter int SIMULATE            = 0,
  parameter int SIMULATE_LONG_CNT   = 20,
  parameter int SIMULATE_REPEAT_CNT = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_BTNS-1:0] pbtn_db,
  input  logic                clr_strobe,
  input  logic [NUM_BTNS-1:0] clr_mask,
  output logic [NUM_BTNS-1:0] press_pulse,
  output logic [NUM_BTNS-1:0] release_pulse,
  output logic [NUM_BTNS-1:0] long_pulse,
  output logic [NUM_BTNS-1:0] repeat_pulse,
  output logic [NUM_BTNS-1:0] held,
  output logic [NUM_BTNS-1:0] press_sticky
);

  localparam int LONG_CNT   = (SIMULATE != 0) ? SIMULATE_LONG_CNT : LONG_PRESS_MS;
  localparam int REPEAT_CNT = (SIMULATE != 0) ? SIMULATE_REPEAT_CNT : REPEAT_MS;
  localparam int PS_TOP     = prescale_top(CLK_FREQUENCY_HZ);
  localparam int PS_W       = (PS_TOP > 0) ? $clog2(PS_TOP + 1) : 1;

  logic tick;

  generate
    if (SIMULATE != 0) begin : g_sim_tick
      assign tick = 1'b1;
    end else begin : g_ms_tick
      localparam logic [PS_W-1:0] PS_TOP_V = PS_TOP[PS_W-1:0];
      logic [PS_W-1:0] ps_cnt_reg;
      logic            tick_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          ps_cnt_reg <= '0;
          tick_reg   <= 1'b0;
        end else begin
          ps_cnt_reg <= (ps_cnt_reg == PS_TOP_V) ? '0 : ps_cnt_reg + {{(PS_W-1){1'b0}}, 1'b1};
          tick_reg   <= (ps_cnt_reg == PS_TOP_V);
        end
      end

      assign tick = tick_reg;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      pbtn_event_fsm #(
        .LONG_CNT   (LONG_CNT),
        .REPEAT_CNT (REPEAT_CNT)
      ) u_fsm (
        .clk           (clk),
        .reset_n       (reset_n),
        .tick          (tick),
        .pbtn          (pbtn_db[gi]),
        .clr           (clr_strobe & clr_mask[gi]),
        .press_pulse   (press_pulse[gi]),
        .release_pulse (release_pulse[gi]),
        .long_pulse    (long_pulse[gi]),
        .repeat_pulse  (repeat_pulse[gi]),
        .held          (held[gi]),
        .press_sticky  (press_sticky[gi])
      );
    end
  endgenerate

endmodule
